// File: rtl/obuf_bias_sel_ctrl_v3_if.sv
// Bundle for the bias/obuf select controller.
// master: loop-table configuration, step/abort pulses in; select stream and status out.
// slave : the controller side of the same signals.
interface obuf_bias_sel_ctrl_v3_if #(
  parameter int LOOP_ID_W     = 3,
  parameter int LOOP_ITER_W   = 16,
  parameter int ADDR_STRIDE_W = 16
);
  logic                     cfg_start;
  logic                     cfg_loop_v;
  logic [LOOP_ID_W-1:0]     cfg_loop_index;
  logic [LOOP_ITER_W-1:0]   cfg_loop_iter;
  logic [ADDR_STRIDE_W-1:0] cfg_obuf_stride;
  logic                     cfg_done;
  logic                     step_v;
  logic                     abort;
  logic                     obuf_bias_sel;
  logic                     obuf_last_pass;
  logic                     sel_v;
  logic                     run_done;
  logic                     busy;
  logic                     err_sticky;

  modport master (
    output cfg_start, cfg_loop_v, cfg_loop_index, cfg_loop_iter, cfg_obuf_stride,
           cfg_done, step_v, abort,
    input  obuf_bias_sel, obuf_last_pass, sel_v, run_done, busy, err_sticky
  );

  modport slave (
    input  cfg_start, cfg_loop_v, cfg_loop_index, cfg_loop_iter, cfg_obuf_stride,
           cfg_done, step_v, abort,
    output obuf_bias_sel, obuf_last_pass, sel_v, run_done, busy, err_sticky
  );
endinterface

// File: rtl/obuf_bias_sel_ctrl_v3.sv
// Bias/obuf read-select generator for the compute array accumulator input.
// A loop nest (iterations-1 and obuf stride per loop) is captured during CFG; loops
// with zero obuf stride are reduction loops. In RUN every step_v yields one select:
// sel=0 (bias) on the first reduction pass of an output tile, 1 (obuf) otherwise,
// plus a last-pass flag, delayed by 1+SEL_DLY cycles to line up with obuf read data.
// Ports: clk, reset (async, active low), bus (slave side of obuf_bias_sel_ctrl_v3_if).
//
// state | meaning
// IDLE  | no nest active; step_v is an error
// CFG   | loop table being written; step_v is an error
// RUN   | counting steps through the nest
module obuf_bias_sel_ctrl_v3 #(
  parameter int NUM_LOOPS     = 8,
  parameter int LOOP_ID_W     = 3,
  parameter int LOOP_ITER_W   = 16,
  parameter int ADDR_STRIDE_W = 16,
  parameter int SEL_DLY       = 1
) (
  input logic                     clk,
  input logic                     reset,
  obuf_bias_sel_ctrl_v3_if.slave  bus
);

  localparam int NLW = LOOP_ID_W + 1;
  localparam logic [NLW-1:0] NUM_LOOPS_C = NLW'(NUM_LOOPS);

  typedef enum logic [1:0] {IDLE, CFG, RUN} state_e;

  typedef struct packed {
    logic v;
    logic sel;
    logic last;
    logic done;
  } stage_t;

  state_e                 state_q, state_d;
  logic [LOOP_ITER_W-1:0] iter_q [NUM_LOOPS];
  logic [LOOP_ITER_W-1:0] iter_d [NUM_LOOPS];
  logic [LOOP_ITER_W-1:0] cnt_q  [NUM_LOOPS];
  logic [LOOP_ITER_W-1:0] cnt_d  [NUM_LOOPS];
  logic [LOOP_ITER_W-1:0] cnt_inc [NUM_LOOPS];
  logic [NUM_LOOPS-1:0]   red_q, red_d;
  logic [NLW-1:0]         nl_q, nl_d;
  logic                   err_q, err_d;
  logic                   flush;
  logic                   all_zero, all_top, carry;
  logic [NLW-1:0]         idx_ext;
  stage_t                 stg_d;
  stage_t                 pipe_q [0:SEL_DLY];

  // Zero-extended so the range check against NUM_LOOPS is meaningful even when
  // the index field can only just address the table.
  assign idx_ext = {1'b0, bus.cfg_loop_index};

  always_comb begin
    // Select/last are derived from the counters as they stand before this step.
    all_zero = 1'b1;
    all_top  = 1'b1;
    for (int i = 0; i < NUM_LOOPS; i++) begin
      if (red_q[i]) begin
        if (cnt_q[i] != '0)        all_zero = 1'b0;
        if (cnt_q[i] != iter_q[i]) all_top  = 1'b0;
      end
    end

    // Ripple increment over the active loops; a carry out of the outermost
    // active loop marks the final step of the nest.
    carry = 1'b1;
    for (int i = 0; i < NUM_LOOPS; i++) begin
      cnt_inc[i] = cnt_q[i];
      if (carry && (NLW'(i) < nl_q)) begin
        if (cnt_q[i] == iter_q[i]) begin
          cnt_inc[i] = '0;
        end else begin
          cnt_inc[i] = cnt_q[i] + LOOP_ITER_W'(1);
          carry      = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    red_d   = red_q;
    nl_d    = nl_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    flush   = 1'b0;
    stg_d   = '0;

    case (state_q)
      IDLE: begin
        if (bus.step_v) err_d = 1'b1;
      end
      CFG: begin
        if (bus.step_v) err_d = 1'b1;
        if (bus.cfg_loop_v) begin
          if (idx_ext >= NUM_LOOPS_C) begin
            err_d = 1'b1;
          end else begin
            for (int i = 0; i < NUM_LOOPS; i++) begin
              if (idx_ext == NLW'(i)) begin
                iter_d[i] = bus.cfg_loop_iter;
                red_d[i]  = (bus.cfg_obuf_stride == '0);
              end
            end
            if (idx_ext + NLW'(1) > nl_q) nl_d = idx_ext + NLW'(1);
          end
        end
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.cfg_done) begin
          state_d = RUN;
          cnt_d   = '{default: '0};
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.step_v) begin
          stg_d.v    = 1'b1;
          stg_d.sel  = ~all_zero;
          stg_d.last = all_top;
          stg_d.done = carry;
          cnt_d      = cnt_inc;
          if (carry) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // cfg_start overrides everything else, including a same-cycle abort.
    if (bus.cfg_start) begin
      state_d = CFG;
      iter_d  = '{default: '0};
      red_d   = '0;
      nl_d    = '0;
      cnt_d   = '{default: '0};
      err_d   = 1'b0;
      flush   = 1'b1;
      stg_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      red_q   <= '0;
      nl_q    <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_LOOPS; i++) begin
        iter_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      red_q   <= red_d;
      nl_q    <= nl_d;
      err_q   <= err_d;
      iter_q  <= iter_d;
      cnt_q   <= cnt_d;
    end
  end

  // Delay line: valid/done shift every cycle so in-flight selects drain after
  // abort; sel/last only load with valid so the outputs hold between pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k <= SEL_DLY; k++) pipe_q[k] <= '0;
    end else if (flush) begin
      for (int k = 0; k <= SEL_DLY; k++) begin
        pipe_q[k].v    <= 1'b0;
        pipe_q[k].done <= 1'b0;
      end
    end else begin
      pipe_q[0].v    <= stg_d.v;
      pipe_q[0].done <= stg_d.done;
      if (stg_d.v) begin
        pipe_q[0].sel  <= stg_d.sel;
        pipe_q[0].last <= stg_d.last;
      end
      for (int k = 1; k <= SEL_DLY; k++) begin
        pipe_q[k].v    <= pipe_q[k-1].v;
        pipe_q[k].done <= pipe_q[k-1].done;
        if (pipe_q[k-1].v) begin
          pipe_q[k].sel  <= pipe_q[k-1].sel;
          pipe_q[k].last <= pipe_q[k-1].last;
        end
      end
    end
  end

  assign bus.obuf_bias_sel  = pipe_q[SEL_DLY].sel;
  assign bus.obuf_last_pass = pipe_q[SEL_DLY].last;
  assign bus.sel_v          = pipe_q[SEL_DLY].v;
  assign bus.run_done       = pipe_q[SEL_DLY].done;
  assign bus.busy           = (state_q != IDLE);
  assign bus.err_sticky     = err_q;

endmodule

// File: tb/tb_obuf_bias_sel_ctrl_v3.sv
module tb_obuf_bias_sel_ctrl_v3;
  localparam int NL  = 8;
  localparam int IDW = 4;
  localparam int ITW = 16;
  localparam int STW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic           d_cfg_start = 1'b0, d_cfg_loop_v = 1'b0, d_cfg_done = 1'b0;
  logic           d_step_v = 1'b0, d_abort = 1'b0;
  logic [IDW-1:0] d_idx = '0;
  logic [ITW-1:0] d_iter = '0;
  logic [STW-1:0] d_stride = '0;

  typedef struct { int n; bit sel; bit last; bit done; } exp_t;
  exp_t exp_q [3][$];

  logic [2:0] busy_v, err_v, outz_v;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: the nest as programmed and the step index within it.
  int     m_iter [NL];
  bit     m_red  [NL];
  int     m_nl;
  bit     m_cfg, m_run, m_err;
  longint m_k, m_total;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int D = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    obuf_bias_sel_ctrl_v3_if #(.LOOP_ID_W(IDW), .LOOP_ITER_W(ITW), .ADDR_STRIDE_W(STW)) bus ();
    assign bus.cfg_start       = d_cfg_start;
    assign bus.cfg_loop_v      = d_cfg_loop_v;
    assign bus.cfg_loop_index  = d_idx;
    assign bus.cfg_loop_iter   = d_iter;
    assign bus.cfg_obuf_stride = d_stride;
    assign bus.cfg_done        = d_cfg_done;
    assign bus.step_v          = d_step_v;
    assign bus.abort           = d_abort;

    obuf_bias_sel_ctrl_v3 #(
      .NUM_LOOPS(NL), .LOOP_ID_W(IDW), .LOOP_ITER_W(ITW),
      .ADDR_STRIDE_W(STW), .SEL_DLY(D)
    ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
    );

    assign busy_v[g] = bus.busy;
    assign err_v[g]  = bus.err_sticky;
    assign outz_v[g] = bus.obuf_bias_sel | bus.obuf_last_pass | bus.sel_v | bus.run_done;

    exp_t e;
    always @(negedge clk) begin
      if (bus.sel_v === 1'b1) begin
        if (exp_q[g].size() == 0) begin
          chk($sformatf("extra_sel_v_d%0d", D), 1, 0);
        end else begin
          e = exp_q[g].pop_front();
          chk($sformatf("latency_d%0d", D), cyc, e.n + 1 + D);
          chk($sformatf("sel_last_done_d%0d", D),
              {bus.obuf_bias_sel, bus.obuf_last_pass, bus.run_done},
              {e.sel, e.last, e.done});
        end
      end else if (bus.run_done === 1'b1) begin
        chk($sformatf("stray_run_done_d%0d", D), 1, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic chk_ctl(input string tag);
    chk({tag, "_busy"}, busy_v, {3{m_cfg | m_run}});
    chk({tag, "_err"},  err_v,  {3{m_err}});
  endtask

  task automatic m_start();
    m_cfg = 1; m_run = 0; m_err = 0; m_nl = 0;
    for (int i = 0; i < NL; i++) begin
      m_iter[i] = 0;
      m_red[i]  = 0;
    end
  endtask

  // Step index k decomposed in mixed radix (iter+1 per loop) gives each loop's position.
  task automatic m_step();
    longint rem;
    int     d;
    bit     s, l, dn;
    if (!m_run) begin
      m_err = 1;
      return;
    end
    rem = m_k; s = 0; l = 1;
    for (int i = 0; i < m_nl; i++) begin
      d   = int'(rem % (m_iter[i] + 1));
      rem = rem / (m_iter[i] + 1);
      if (m_red[i]) begin
        if (d != 0)         s = 1;
        if (d != m_iter[i]) l = 0;
      end
    end
    dn = (m_k == m_total - 1);
    for (int g = 0; g < 3; g++) exp_q[g].push_back('{n: cyc, sel: s, last: l, done: dn});
    if (dn) m_run = 0;
    m_k++;
  endtask

  task automatic do_cfg_start();
    d_cfg_start = 1; m_start();
    tick();
    d_cfg_start = 0;
  endtask

  task automatic do_loop(input int idx, input int iter, input int stride);
    d_cfg_loop_v = 1; d_idx = IDW'(idx); d_iter = ITW'(iter); d_stride = STW'(stride);
    if (m_cfg) begin
      if (idx >= NL) m_err = 1;
      else begin
        m_iter[idx] = iter;
        m_red[idx]  = (stride == 0);
        if (idx + 1 > m_nl) m_nl = idx + 1;
      end
    end
    tick();
    d_cfg_loop_v = 0;
  endtask

  task automatic do_cfg_done(input bit with_step);
    d_cfg_done = 1; d_step_v = with_step;
    if (with_step) m_step();
    if (m_cfg) begin
      m_cfg = 0; m_run = 1; m_k = 0; m_total = 1;
      for (int i = 0; i < m_nl; i++) m_total = m_total * (m_iter[i] + 1);
    end
    tick();
    d_cfg_done = 0; d_step_v = 0;
  endtask

  task automatic do_step();
    d_step_v = 1; m_step();
    tick();
    d_step_v = 0;
  endtask

  task automatic do_abort(input bit with_start);
    d_abort = 1; d_cfg_start = with_start;
    if (with_start) m_start();
    else begin
      m_cfg = 0; m_run = 0;
    end
    tick();
    d_abort = 0; d_cfg_start = 0;
  endtask

  task automatic run_steps(input int n, input int max_gap);
    for (int s = 0; s < n; s++) begin
      do_step();
      if (max_gap > 0) idle(int'($urandom_range(0, max_gap)));
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int nl, st, ab;
    reset = 1'b1;
    m_cfg = 0; m_run = 0; m_err = 0; m_nl = 0; m_k = 0; m_total = 1;
    #3 reset = 1'b0;
    #5;
    chk("rst_outputs", outz_v, 3'b000);
    chk("rst_busy", busy_v, 3'b000);
    chk("rst_err", err_v, 3'b000);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    tick();
    chk("post_rst_outputs", outz_v, 3'b000);

    // Reduction innermost: sel 0,1,1,0,1,1 last 0,0,1,0,0,1
    do_cfg_start();
    chk_ctl("cfg_a");
    do_loop(0, 2, 0);
    do_loop(1, 1, 16);
    do_cfg_done(0);
    chk_ctl("run_a");
    run_steps(6, 0);
    idle(6);
    chk_ctl("done_a");

    // No reduction loops: sel=0, last=1 every step
    do_cfg_start();
    do_loop(0, 3, 4);
    do_cfg_done(0);
    run_steps(4, 1);
    idle(6);
    chk_ctl("done_b");

    // Reduction outer: sel 0,0,1,1,1,1 last 0,0,0,0,1,1
    do_cfg_start();
    do_loop(0, 1, 1);
    do_loop(1, 2, 0);
    do_cfg_done(0);
    run_steps(6, 2);
    idle(6);
    chk_ctl("done_c");

    // Abort mid-run, then a fresh run must start from bias
    do_cfg_start();
    do_loop(0, 2, 0);
    do_loop(1, 1, 16);
    do_cfg_done(0);
    run_steps(3, 0);
    do_abort(0);
    chk_ctl("abort");
    idle(6);
    do_step();
    chk_ctl("idle_step");
    idle(6);
    do_cfg_start();
    chk_ctl("err_clear");
    do_loop(0, 2, 0);
    do_loop(1, 1, 16);
    do_cfg_done(0);
    run_steps(6, 0);
    idle(6);
    chk_ctl("done_rerun");

    // Out-of-range index: flagged and not written
    do_cfg_start();
    do_loop(0, 1, 0);
    do_loop(NL, 5, 0);
    chk_ctl("bad_idx");
    do_cfg_done(0);
    run_steps(2, 0);
    idle(6);
    chk_ctl("done_bad_idx");

    // Empty table: single-step nest
    do_cfg_start();
    do_cfg_done(0);
    do_step();
    idle(6);
    chk_ctl("done_empty");

    // step_v together with cfg_done is dropped and flagged
    do_cfg_start();
    do_loop(0, 1, 0);
    do_cfg_done(1);
    chk_ctl("step_with_done");
    run_steps(2, 0);
    idle(6);

    // abort and cfg_start together: cfg_start wins
    do_cfg_start();
    do_loop(1, 3, 0);
    do_abort(1);
    chk_ctl("abort_vs_start");
    do_loop(0, 1, 0);
    do_cfg_done(0);
    run_steps(2, 0);
    idle(6);
    chk_ctl("done_abort_vs_start");

    // Random nests, with holes, rewrites and occasional aborts
    for (int r = 0; r < 16; r++) begin
      do_cfg_start();
      nl = int'($urandom_range(1, 4));
      for (int i = 0; i < nl; i++) begin
        st = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 255));
        if (i == nl - 1 || $urandom_range(0, 3) != 0)
          do_loop(i, int'($urandom_range(0, 3)), st);
      end
      if ($urandom_range(0, 3) == 0) do_loop(0, int'($urandom_range(0, 3)), 0);
      do_cfg_done(0);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(m_total) - 1)) : -1;
      if (ab >= 0) begin
        run_steps(ab, 1);
        do_abort(0);
      end else begin
        run_steps(int'(m_total), 2);
      end
      idle(6);
      chk_ctl($sformatf("rand%0d", r));
    end

    // Full 16-bit wrap on the innermost loop, back-to-back steps
    do_cfg_start();
    do_loop(0, 65535, 0);
    do_cfg_done(0);
    run_steps(65536, 0);
    idle(6);
    chk_ctl("done_wrap");

    for (int g = 0; g < 3; g++) chk($sformatf("pending_%0d", g), exp_q[g].size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
